// File: rtl/ps2_move_decoder.sv
// ps2_move_decoder
// Turns PS/2 scan-code words {expand, break, code} into 2048 move commands
// (UP/DOWN/LEFT/RIGHT/RESTART), suppresses typematic repeats while a key is
// held, and queues commands in a show-ahead FIFO with a valid/ready output.

module ps2_move_decoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       key_data,
  input  logic             key_ready,
  input  logic             enable,
  output logic             cmd_valid,
  output logic [2:0]       cmd_code,
  input  logic             cmd_ready,
  output logic [CNT_W-1:0] fifo_level,
  output logic             overflow,
  input  logic             ovf_clear
);

  localparam int AW = (CNT_W > 1) ? CNT_W - 1 : 1;
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(FIFO_DEPTH);

  localparam logic [2:0] CMD_UP      = 3'd0;
  localparam logic [2:0] CMD_DOWN    = 3'd1;
  localparam logic [2:0] CMD_LEFT    = 3'd2;
  localparam logic [2:0] CMD_RIGHT   = 3'd3;
  localparam logic [2:0] CMD_RESTART = 3'd4;

  // Map {expand, code} to {hit, command}; the break bit is ignored here so
  // make and break forms of a key resolve to the same command slot.
  function automatic logic [3:0] decode_key(input logic [9:0] kd);
    logic [3:0] res;
    res = 4'b0000;
    case ({kd[9], kd[7:0]})
      9'h175:  res = {1'b1, CMD_UP};
      9'h01D:  res = {1'b1, CMD_UP};
      9'h172:  res = {1'b1, CMD_DOWN};
      9'h01B:  res = {1'b1, CMD_DOWN};
      9'h16B:  res = {1'b1, CMD_LEFT};
      9'h01C:  res = {1'b1, CMD_LEFT};
      9'h174:  res = {1'b1, CMD_RIGHT};
      9'h023:  res = {1'b1, CMD_RIGHT};
      9'h02D:  res = {1'b1, CMD_RESTART};
      default: res = 4'b0000;
    endcase
    return res;
  endfunction

  logic       key_hit;
  logic [2:0] key_cmd;
  logic       key_break;
  logic [4:0] key_mask;
  logic       key_held;

  logic [4:0] held;

  logic       vld_p0;
  logic [2:0] cmd_p0;

  logic [2:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic [2:0]       last_code;
  logic             ovf_q;

  logic full;
  logic do_rd;
  logic do_wr;
  logic drop;

  assign {key_hit, key_cmd} = decode_key(key_data);
  assign key_break = key_data[8];
  assign key_mask  = 5'b00001 << key_cmd;
  assign key_held  = |(held & key_mask);

  // Held bits: arrow and letter forms share a bit; tracking runs even when
  // command generation is disabled so a key held across enable stays quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      held <= '0;
    end else if (key_ready && key_hit) begin
      if (key_break) held <= held & ~key_mask;
      else           held <= held | key_mask;
    end
  end

  // ---- stage p0: registered decode result, pushed into the FIFO next cycle
  always_ff @(posedge clk) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= key_ready & key_hit & ~key_break & ~key_held & enable;
  end

  // Decoded command payload travels with vld_p0 and needs no reset.
  always_ff @(posedge clk) begin
    cmd_p0 <= key_cmd;
  end

  assign full      = (count == FULL_LVL);
  assign cmd_valid = (count != '0);
  assign do_rd     = cmd_valid & cmd_ready;
  // When full, a same-cycle pop frees the slot the push lands in.
  assign do_wr     = vld_p0 & (~full | do_rd);
  assign drop      = vld_p0 & full & ~do_rd;

  // ---- stage p1: FIFO storage write
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= cmd_p0;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Remember the last popped head so cmd_code holds steady while the queue is empty.
  always_ff @(posedge clk) begin
    if (rst)        last_code <= '0;
    else if (do_rd) last_code <= mem[rd_ptr];
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk) begin
    if (rst)            ovf_q <= 1'b0;
    else if (drop)      ovf_q <= 1'b1;
    else if (ovf_clear) ovf_q <= 1'b0;
  end

  assign cmd_code   = cmd_valid ? mem[rd_ptr] : last_code;
  assign fifo_level = count;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Directed testbench for ps2_move_decoder: reset, decode latency, typematic
// suppression, overflow, full-with-pop, enable gating and mid-queue reset.

module tb_ps2_move_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] key_data;
  logic       key_ready;
  logic       enable;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic       cmd_ready;
  logic [2:0] fifo_level;
  logic       overflow;
  logic       ovf_clear;

  int checks = 0;
  int errors = 0;

  ps2_move_decoder #(.FIFO_DEPTH(4), .CNT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_data   (key_data),
    .key_ready  (key_ready),
    .enable     (enable),
    .cmd_valid  (cmd_valid),
    .cmd_code   (cmd_code),
    .cmd_ready  (cmd_ready),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .ovf_clear  (ovf_clear)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle key strobe; returns just after the edge that sampled it.
  task automatic key(input logic [9:0] d);
    key_data  = d;
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    key_data  = 10'h000;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [2:0] drain_exp [4];

  initial begin
    rst = 1'b1; key_data = '0; key_ready = 1'b0; enable = 1'b1;
    cmd_ready = 1'b0; ovf_clear = 1'b0;
    #1;
    tick(); tick();
    rst = 1'b0;

    // 1. Reset state
    chk("rst_valid", cmd_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_code", cmd_code, 0);

    // 2. Single key: visible two cycles after the strobe cycle
    key(10'h275);
    chk("single_n1_valid", cmd_valid, 0);
    tick();
    chk("single_valid", cmd_valid, 1);
    chk("single_code", cmd_code, 0);
    chk("single_level", fifo_level, 1);
    cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
    chk("single_pop_level", fifo_level, 0);
    chk("single_pop_valid", cmd_valid, 0);
    key(10'h375);

    // 3. Typematic repeat and shared held bit
    key(10'h01C); key(10'h01C); key(10'h01C); key(10'h11C); key(10'h01C);
    tick(); tick();
    chk("repeat_level", fifo_level, 2);
    chk("repeat_head", cmd_code, 2);
    key(10'h26B);
    tick(); tick();
    chk("samebit_level", fifo_level, 2);
    cmd_ready = 1'b1;
    tick();
    chk("repeat_pop1_level", fifo_level, 1);
    chk("repeat_pop1_head", cmd_code, 2);
    tick();
    cmd_ready = 1'b0;
    chk("repeat_pop2_level", fifo_level, 0);
    chk("empty_hold_code", cmd_code, 2);
    key(10'h11C);

    // 4. Overflow with five distinct commands into a depth-4 queue
    key(10'h275); key(10'h375);
    key(10'h01B); key(10'h11B);
    key(10'h01C); key(10'h11C);
    key(10'h023); key(10'h123);
    key(10'h02D); key(10'h12D);
    tick(); tick();
    chk("ovf_level", fifo_level, 4);
    chk("ovf_flag", overflow, 1);
    chk("ovf_head", cmd_code, 0);
    ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
    chk("ovf_cleared", overflow, 0);
    // Drop and clear in the same cycle: set wins
    key(10'h275);
    ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
    chk("ovf_set_wins", overflow, 1);
    chk("ovf_set_wins_level", fifo_level, 4);
    key(10'h375);
    ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
    chk("ovf_cleared2", overflow, 0);

    // 5. Full with simultaneous pop: RIGHT becomes the tail
    key(10'h023);
    cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
    chk("fullpop_level", fifo_level, 4);
    chk("fullpop_ovf", overflow, 0);
    drain_exp[0] = 3'd1; drain_exp[1] = 3'd2; drain_exp[2] = 3'd3; drain_exp[3] = 3'd3;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_head%0d", i), cmd_code, drain_exp[i]);
      cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
    end
    chk("drain_level", fifo_level, 0);
    key(10'h123);

    // 6. Enable gating and held tracking while disabled
    enable = 1'b0;
    key(10'h02D);
    tick(); tick();
    chk("dis_level", fifo_level, 0);
    chk("dis_valid", cmd_valid, 0);
    enable = 1'b1;
    key(10'h02D);
    tick(); tick();
    chk("held_after_dis_level", fifo_level, 0);
    key(10'h12D); key(10'h02D);
    tick(); tick();
    chk("restart_valid", cmd_valid, 1);
    chk("restart_code", cmd_code, 4);
    chk("restart_level", fifo_level, 1);

    // Reset mid-queue
    key(10'h275);
    tick(); tick();
    chk("prerst_level", fifo_level, 2);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_level", fifo_level, 0);
    chk("midrst_valid", cmd_valid, 0);
    chk("midrst_code", cmd_code, 0);
    // Reset while a decode is in flight discards it and clears held bits
    key(10'h01B);
    rst = 1'b1; tick(); rst = 1'b0;
    tick(); tick();
    chk("inflight_discard_level", fifo_level, 0);
    key(10'h01B);
    tick(); tick();
    chk("held_cleared_level", fifo_level, 1);
    chk("held_cleared_code", cmd_code, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
